llc_snoop_responder: RTL

- Responder side of the LLC shared-bus protocol. The cache engine initiates READ/WRITE/INVALIDATE/RWIM; this block services the same operations when another cache snoops them.
- Per snooped operation: looks up the set through the cache array port, drives the snoop result (HIT/HITM/NOHIT), updates the MESI state, and sequences any writeback and L1 messages.
- Sits between the bus snoop interface and the cache_mem array, alongside the cache module.

---
 rtl/llc_snoop_responder_pkg.sv | 35 +++
 rtl/llc_snoop_responder_way_match.sv | 39 +++
 rtl/llc_snoop_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/llc_snoop_responder_pkg.sv
// Bus-side and cache-line types shared by the LLC snoop responder and its way matcher.
package pkg_bus;
  typedef enum logic [2:0] {
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } bus_operation_e;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    HITM  = 2'd1,
    NOHIT = 2'd2
  } snoop_result_e;

  typedef enum logic [1:0] {
    GETLINE        = 2'd1,
    INVALIDATELINE = 2'd3
  } l1_msg_e;
endpackage

package pkg_line;
  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  localparam int unsigned LINE_N_WAY      = 16;
  localparam int unsigned LINE_ADDR_SIZE  = 32;
  localparam int unsigned LINE_INDEX_SIZE = 14;
  localparam int unsigned LINE_TAG_SIZE   = 12;
  localparam int unsigned LINE_OFFSET_SIZE = LINE_ADDR_SIZE - LINE_INDEX_SIZE - LINE_TAG_SIZE;
endpackage

// File: rtl/llc_snoop_responder_way_match.sv
// Tag compare across all ways of a set with lowest-way priority and a multi-hit flag.
module snoop_way_match
  import pkg_line::*;
#(
  parameter int N_WAY    = 16,
  parameter int TAG_SIZE = 12
) (
  input  logic [N_WAY*TAG_SIZE-1:0] tags,
  input  logic [N_WAY*2-1:0]        mesi,
  input  logic [TAG_SIZE-1:0]       tag,
  output logic                      hit,
  output logic [$clog2(N_WAY)-1:0]  way,
  output logic                      multi_hit
);
  localparam int WAY_W = $clog2(N_WAY);

  logic [N_WAY-1:0] match;

  always_comb begin
    match = '0;
    for (int w = 0; w < N_WAY; w++) begin
      match[w] = (mesi[w*2 +: 2] != MESI_I) && (tags[w*TAG_SIZE +: TAG_SIZE] == tag);
    end
  end

  // Scan from the top so the lowest matching way wins.
  always_comb begin
    hit = 1'b0;
    way = '0;
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit = 1'b1;
        way = w[WAY_W-1:0];
      end
    end
  end

  assign multi_hit = (match & (match - {{(N_WAY-1){1'b0}}, 1'b1})) != '0;
endmodule

// File: rtl/llc_snoop_responder.sv
// Snoop responder: set lookup, HIT/HITM/NOHIT result, MESI update, then GETLINE/WB/INVALIDATELINE.
// Optional SNOOP_STATS_EN adds saturating result counters on stat_hit/stat_hitm/stat_nohit.
module llc_snoop_responder
  import pkg_bus::*;
  import pkg_line::*;
#(
  parameter int N_WAY      = 16,
  parameter int ADDR_SIZE  = 32,
  parameter int INDEX_SIZE = 14,
  parameter int TAG_SIZE   = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         snp_valid,
  output logic                         snp_ready,
  input  bus_operation_e               snp_op,
  input  logic [ADDR_SIZE-1:0]         snp_addr,
  output logic                         arr_rd_en,
  output logic [INDEX_SIZE-1:0]        arr_index,
  input  logic [N_WAY*TAG_SIZE-1:0]    arr_rd_tag,
  input  logic [N_WAY*2-1:0]           arr_rd_mesi,
  output logic                         arr_wr_en,
  output logic [$clog2(N_WAY)-1:0]     arr_wr_way,
  output mesi_e                        arr_wr_mesi,
  output logic                         res_valid,
  output snoop_result_e                res_result,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_SIZE-1:0]         wb_addr,
  output logic                         l1_valid,
  input  logic                         l1_ready,
  output l1_msg_e                      l1_msg,
  output logic [ADDR_SIZE-1:0]         l1_addr,
  output logic                         proto_err,
  output logic [31:0]                  stat_hit,
  output logic [31:0]                  stat_hitm,
  output logic [31:0]                  stat_nohit
);
  localparam int OFFSET_SIZE = ADDR_SIZE - INDEX_SIZE - TAG_SIZE;
  localparam int LINE_W      = ADDR_SIZE - OFFSET_SIZE;
  localparam int WAY_W       = $clog2(N_WAY);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DECIDE, S_GETL, S_WB, S_INVL} state_e;

  state_e                  state_q, state_d;
  bus_operation_e          op_q, op_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [N_WAY*TAG_SIZE-1:0] tags_q, tags_d;
  logic [N_WAY*2-1:0]      mesi_q, mesi_d;
  logic                    need_wb_q, need_wb_d, need_invl_q, need_invl_d;

  logic                    hit, multi_hit;
  logic [WAY_W-1:0]        hit_way;
  mesi_e                   cur_mesi, new_mesi;
  snoop_result_e           result;
  logic                    act_getl, act_wb, act_invl, illegal;
  logic                    unused_offset;

  assign unused_offset = ^snp_addr[OFFSET_SIZE-1:0];

  snoop_way_match #(.N_WAY(N_WAY), .TAG_SIZE(TAG_SIZE)) u_way_match (
    .tags      (tags_q),
    .mesi      (mesi_q),
    .tag       (line_q[LINE_W-1 -: TAG_SIZE]),
    .hit       (hit),
    .way       (hit_way),
    .multi_hit (multi_hit)
  );

  assign cur_mesi = hit ? mesi_e'(mesi_q[{hit_way, 1'b0} +: 2]) : MESI_I;

  // Protocol table: a miss looks like state I, so every op falls through to NOHIT.
  always_comb begin
    new_mesi = cur_mesi;
    result   = NOHIT;
    act_getl = 1'b0;
    act_wb   = 1'b0;
    act_invl = 1'b0;
    illegal  = multi_hit;
    case (op_q)
      READ: if (cur_mesi != MESI_I) begin
        new_mesi = MESI_S;
        result   = (cur_mesi == MESI_M) ? HITM : HIT;
        act_getl = (cur_mesi == MESI_M);
        act_wb   = (cur_mesi == MESI_M);
      end
      RWIM: if (cur_mesi != MESI_I) begin
        new_mesi = MESI_I;
        result   = (cur_mesi == MESI_M) ? HITM : HIT;
        act_getl = (cur_mesi == MESI_M);
        act_wb   = (cur_mesi == MESI_M);
        act_invl = 1'b1;
      end
      INVALIDATE: begin
        if (cur_mesi == MESI_S) begin
          new_mesi = MESI_I;
          act_invl = 1'b1;
        end else if (cur_mesi != MESI_I) begin
          illegal = 1'b1;
        end
      end
      WRITE: if (cur_mesi == MESI_M || cur_mesi == MESI_E) illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    line_d      = line_q;
    tags_d      = tags_q;
    mesi_d      = mesi_q;
    need_wb_d   = need_wb_q;
    need_invl_d = need_invl_q;
    snp_ready   = 1'b0;
    arr_rd_en   = 1'b0;
    arr_wr_en   = 1'b0;
    res_valid   = 1'b0;
    wb_valid    = 1'b0;
    l1_valid    = 1'b0;
    l1_msg      = GETLINE;
    proto_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        snp_ready = 1'b1;
        if (snp_valid && rst) begin
          arr_rd_en = 1'b1;
          op_d      = snp_op;
          line_d    = snp_addr[ADDR_SIZE-1:OFFSET_SIZE];
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        tags_d  = arr_rd_tag;
        mesi_d  = arr_rd_mesi;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        res_valid   = 1'b1;
        arr_wr_en   = (new_mesi != cur_mesi);
        proto_err   = illegal;
        need_wb_d   = act_wb;
        need_invl_d = act_invl;
        state_d     = act_getl ? S_GETL : act_wb ? S_WB : act_invl ? S_INVL : S_IDLE;
      end
      S_GETL: begin
        l1_valid = 1'b1;
        if (l1_ready) state_d = need_wb_q ? S_WB : need_invl_q ? S_INVL : S_IDLE;
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = need_invl_q ? S_INVL : S_IDLE;
      end
      S_INVL: begin
        l1_valid = 1'b1;
        l1_msg   = INVALIDATELINE;
        if (l1_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign arr_index   = arr_rd_en ? snp_addr[OFFSET_SIZE +: INDEX_SIZE] : line_q[INDEX_SIZE-1:0];
  assign arr_wr_way  = hit_way;
  assign arr_wr_mesi = new_mesi;
  assign res_result  = res_valid ? result : NOHIT;
  assign wb_addr     = {line_q, {OFFSET_SIZE{1'b0}}};
  assign l1_addr     = {line_q, {OFFSET_SIZE{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= READ;
      line_q      <= '0;
      tags_q      <= '0;
      mesi_q      <= '0;
      need_wb_q   <= 1'b0;
      need_invl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      line_q      <= line_d;
      tags_q      <= tags_d;
      mesi_q      <= mesi_d;
      need_wb_q   <= need_wb_d;
      need_invl_q <= need_invl_d;
    end
  end

`ifdef SNOOP_STATS_EN
  logic [31:0] hit_cnt_q, hitm_cnt_q, nohit_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q   <= '0;
      hitm_cnt_q  <= '0;
      nohit_cnt_q <= '0;
    end else if (res_valid) begin
      case (res_result)
        HIT:     if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        HITM:    if (hitm_cnt_q != '1) hitm_cnt_q <= hitm_cnt_q + 32'd1;
        NOHIT:   if (nohit_cnt_q != '1) nohit_cnt_q <= nohit_cnt_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign stat_hit   = hit_cnt_q;
  assign stat_hitm  = hitm_cnt_q;
  assign stat_nohit = nohit_cnt_q;
`else
  assign stat_hit   = '0;
  assign stat_hitm  = '0;
  assign stat_nohit = '0;
`endif
endmodule
